// File: rtl/add_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_sub_pkg
//  Description : Shared types and default widths for the sequential wide
//                add/sub datapath and its CLA slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_sub_pkg;

    // Default operand width and slice width
    localparam int AS_N_DEFAULT = 32;
    localparam int AS_W_DEFAULT = 8;

    // Control states of the multi-cycle engine
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } as_state_t;

endpackage : add_sub_pkg
`default_nettype wire

// File: rtl/cla_add_sub_slice.sv
`default_nettype none
// ============================================================================
//  Module      : cla_add_sub_slice
//  Description : Combinational W-bit carry-lookahead adder slice.
//                Every carry is formed directly from generate/propagate terms
//                and the slice carry-in, so no carry ripples bit to bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_add_sub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W-1:0] w_p;
    logic [W-1:0] w_g;
    logic [W:0]   w_c;
    logic         w_acc;
    logic         w_prop;

    assign w_p = x_i ^ y_i;
    assign w_g = x_i & y_i;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        w_c    = '0;
        w_acc  = 1'b0;
        w_prop = 1'b0;
        w_c[0] = cin_i;
        for (int i = 0; i < W; i++) begin
            w_acc  = w_g[i];
            w_prop = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc  = w_acc | (w_prop & w_g[j]);
                w_prop = w_prop & w_p[j];
            end
            w_c[i+1] = w_acc | (w_prop & cin_i);
        end
    end

    assign sum_o  = w_p ^ w_c[W-1:0];
    assign cout_o = w_c[W];

endmodule : cla_add_sub_slice
`default_nettype wire

// File: rtl/seq_wide_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : seq_wide_add_sub
//  Description : Multi-cycle N-bit adder/subtractor that reuses one W-bit CLA
//                slice, least-significant slice first, with valid/ready
//                handshakes on the operand and result sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_wide_add_sub
    import add_sub_pkg::*;
#(
    parameter int N = AS_N_DEFAULT,
    parameter int W = AS_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic         cin,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         cout,
    output logic         v
);

    localparam int K     = N / W;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

    // Reject widths that do not split into at least two whole slices
    if ((N % W) != 0 || K < 2) begin : g_param_check
        $error("seq_wide_add_sub: N must be a multiple of W with N/W >= 2");
    end

    as_state_t    state_q, state_d;
    logic [N-1:0] x_q, x_d;
    logic [N-1:0] y_q, y_d;       // y already inverted for subtraction
    logic [N-1:0] res_q, res_d;
    logic         carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic         cout_q, cout_d;
    logic         v_q, v_d;

    logic [W-1:0] w_sum;
    logic         w_cout;

    cla_add_sub_slice #(
        .W (W)
    ) u_slice (
        .x_i    (x_q[W-1:0]),
        .y_i    (y_q[W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    // Next-state and datapath control for IDLE -> RUN -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is x + ~y + ~borrow_in
                    x_d     = x;
                    y_d     = sub ? ~y : y;
                    carry_d = sub ? ~cin : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {w_sum, res_q[N-1:W]};
                x_d     = x_q >> W;
                y_d     = y_q >> W;
                carry_d = w_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    // Top slice is in the low bits now, so its MSBs are the operand MSBs
                    cout_d  = w_cout;
                    v_d     = (x_q[W-1] == y_q[W-1]) && (w_sum[W-1] != x_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = res_q;
    assign cout      = cout_q;
    assign v         = v_q;

endmodule : seq_wide_add_sub
`default_nettype wire

// File: tb/tb_seq_wide_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_wide_add_sub
//  Description : Directed and randomised self-checking bench for
//                seq_wide_add_sub at N=32, W=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_wide_add_sub;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sub;
    logic        cin;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        cout;
    logic        v;

    int n_cmp;
    int n_fail;

    seq_wide_add_sub #(
        .N (32),
        .W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .cin       (cin),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout),
        .v         (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, v, out} from plain wide arithmetic
    function automatic logic [33:0] model(input logic s, input logic c,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        logic        vv;
        if (!s) begin
            r  = {1'b0, a} + {1'b0, b} + 33'(c);
            vv = (a[31] == b[31]) && (r[31] != a[31]);
        end else begin
            r     = {1'b0, a} - {1'b0, b} - 33'(c);
            r[32] = ~r[32];
            vv    = (a[31] != b[31]) && (r[31] != a[31]);
        end
        return {r[32], vv, r[31:0]};
    endfunction

    task automatic start_op(input logic s, input logic c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("in_ready_before_accept", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        sub      = s;
        cin      = c;
        x        = a;
        y        = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = 32'h0;
        y        = 32'h0;
    endtask

    task automatic wait_done(output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) got = 1'b1;
            else chk("in_ready_while_busy", 64'(in_ready), 64'(0));
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $error("FAIL wait_done: observed no out_valid, required out_valid within 20 cycles");
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_consume", 64'(out_valid), 64'(0));
        chk("in_ready_after_consume", 64'(in_ready), 64'(1));
    endtask

    task automatic check_res(input string tag, input logic [31:0] eo, input logic ec, input logic ev);
        chk({tag, "_out"}, 64'(out), 64'(eo));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_v"}, 64'(v), 64'(ev));
    endtask

    initial begin
        int          lat;
        logic [31:0] ra, rb;
        logic        rs, rc;
        logic [33:0] exp_r;

        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sub       = 1'b0;
        cin       = 1'b0;
        x         = 32'h0;
        y         = 32'h0;

        // Reset state, idle with no stimulus
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_in_ready", 64'(in_ready), 64'(1));
            chk("reset_out_valid", 64'(out_valid), 64'(0));
            check_res("reset", 32'h0, 1'b0, 1'b0);
        end

        // Add with full carry propagation; latency check
        start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_done(lat);
        chk("latency_add", 64'(lat), 64'(4));
        check_res("add_ffffffff_1", 32'h0000_0000, 1'b1, 1'b0);
        consume();

        // Sub with signed overflow
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001);
        wait_done(lat);
        chk("latency_sub", 64'(lat), 64'(4));
        check_res("sub_80000000_1", 32'h7FFF_FFFF, 1'b1, 1'b1);
        consume();

        // Sub with borrow out
        start_op(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001);
        wait_done(lat);
        check_res("sub_0_1", 32'hFFFF_FFFF, 1'b0, 1'b0);
        consume();

        // Sub with borrow-in
        start_op(1'b1, 1'b1, 32'h0000_0005, 32'h0000_0003);
        wait_done(lat);
        check_res("sub_5_3_b", 32'h0000_0001, 1'b1, 1'b0);
        consume();

        // Result held in DONE under back-pressure; in_valid pulse ignored
        start_op(1'b0, 1'b1, 32'h0000_00FF, 32'h0000_0001);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                in_valid = 1'b1;
                sub      = 1'b0;
                cin      = 1'b0;
                x        = 32'h1111_1111;
                y        = 32'h2222_2222;
            end else begin
                in_valid = 1'b0;
            end
            chk("hold_out_valid", 64'(out_valid), 64'(1));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
            check_res("hold", 32'h0000_0101, 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_queued_op", 64'(out_valid), 64'(0));
        end

        // Asynchronous reset two cycles into RUN aborts the operation
        start_op(1'b0, 1'b0, 32'hAAAA_AAAA, 32'h0000_1234);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_abort_in_ready", 64'(in_ready), 64'(1));
        chk("post_abort_out_valid", 64'(out_valid), 64'(0));
        start_op(1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111);
        wait_done(lat);
        check_res("add_after_abort", 32'h2345_6789, 1'b0, 1'b0);
        consume();

        // Random operations against the arithmetic model
        for (int n = 0; n < 3000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            start_op(rs, rc, ra, rb);
            wait_done(lat);
            exp_r = model(rs, rc, ra, rb);
            chk("random", 64'({cout, v, out}), 64'(exp_r));
            consume();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_seq_wide_add_sub
`default_nettype wire
